// File: rtl/branch_predictor_if.sv
//------------------------------------------------------------------------------
// branch_predictor_if : fetch-lookup and EX-resolve signals of the predictor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface branch_predictor_if;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        ex_valid_i;
    logic        ex_is_branch_i;
    logic [31:0] ex_pc_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    modport slave (
        input  if_pc_i, ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i,
               ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               branch_cnt_o, mispred_cnt_o
    );

    modport master (
        output if_pc_i, ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i,
               ex_target_i, ex_pred_taken_i, ex_pred_target_i,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               branch_cnt_o, mispred_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
//------------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB with 2-bit counters and mispredict stats
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx, ex_idx;
    logic [TAG_W-1:0] lk_tag, ex_tag;
    logic             lk_hit, ex_hit, res;
    logic             mp_taken, mp_not_taken;
    logic             upd_en;
    logic [1:0]       upd_ctr;
    logic [31:0]      upd_tgt;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{bp.if_pc_i[1:0], bp.ex_pc_i[1:0]};

    // Lookup reads only registered state, so an update is never bypassed
    assign lk_idx = bp.if_pc_i[IDX_W+1:2];
    assign lk_tag = bp.if_pc_i[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bp.pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    assign bp.pred_target_o = bp.pred_taken_o ? target_q[lk_idx] : bp.if_pc_i + 32'd4;

    assign res          = bp.ex_valid_i && bp.ex_is_branch_i;
    assign mp_taken     = bp.ex_taken_i &&
                          (!bp.ex_pred_taken_i || (bp.ex_pred_target_i != bp.ex_target_i));
    assign mp_not_taken = !bp.ex_taken_i && bp.ex_pred_taken_i;

    assign bp.mispredict_o  = res && (mp_taken || mp_not_taken);
    assign bp.redirect_pc_o = !res         ? 32'd0 :
                              mp_taken     ? bp.ex_target_i :
                              mp_not_taken ? bp.ex_pc_i + 32'd4 : 32'd0;

    assign ex_idx = bp.ex_pc_i[IDX_W+1:2];
    assign ex_tag = bp.ex_pc_i[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        upd_en  = 1'b0;
        upd_ctr = ctr_q[ex_idx];
        upd_tgt = target_q[ex_idx];
        if (res) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (bp.ex_taken_i) begin
                    upd_ctr = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                    upd_tgt = bp.ex_target_i;
                end else begin
                    upd_ctr = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (bp.ex_taken_i) begin
                upd_en  = 1'b1;
                upd_ctr = 2'b10;
                upd_tgt = bp.ex_target_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= upd_tgt;
            ctr_q[ex_idx]    <= upd_ctr;
        end
    end

    // Statistics saturate rather than wrap
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (res && (branch_cnt_q != 32'hFFFF_FFFF))
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (bp.mispredict_o && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bp.branch_cnt_o  = branch_cnt_q;
    assign bp.mispred_cnt_o = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//------------------------------------------------------------------------------
// tb_branch_predictor : directed scoreboard bench for branch_predictor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_predictor_if bp();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic expv(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %h expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        @(negedge clk);
        bp.ex_valid_i       = v;
        bp.ex_is_branch_i   = br;
        bp.ex_pc_i          = pc;
        bp.ex_taken_i       = tk;
        bp.ex_target_i      = tgt;
        bp.ex_pred_taken_i  = ptk;
        bp.ex_pred_target_i = ptgt;
        #2;
    endtask

    // Fetch and resolve the same PC in one cycle, feeding the live prediction back
    task automatic res_fb(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        @(negedge clk);
        bp.ex_valid_i = 1'b0;
        bp.if_pc_i    = pc;
        #1;
        bp.ex_valid_i       = 1'b1;
        bp.ex_is_branch_i   = 1'b1;
        bp.ex_pc_i          = pc;
        bp.ex_taken_i       = tk;
        bp.ex_target_i      = tgt;
        bp.ex_pred_taken_i  = bp.pred_taken_o;
        bp.ex_pred_target_i = bp.pred_target_o;
        #1;
    endtask

    task automatic idle_look(input logic [31:0] pc);
        @(negedge clk);
        bp.ex_valid_i     = 1'b0;
        bp.ex_is_branch_i = 1'b0;
        bp.if_pc_i        = pc;
        #2;
    endtask

    task automatic look_chk(input logic pt, input logic [31:0] tgt);
        expv("pred_taken", {31'd0, pt});
        expv("pred_target", tgt);
        chk({31'd0, bp.pred_taken_o});
        chk(bp.pred_target_o);
    endtask

    task automatic mp_chk(input logic mp, input logic [31:0] rd);
        expv("mispredict", {31'd0, mp});
        expv("redirect_pc", rd);
        chk({31'd0, bp.mispredict_o});
        chk(bp.redirect_pc_o);
    endtask

    task automatic cnt_chk(input logic [31:0] b, input logic [31:0] m);
        expv("branch_cnt", b);
        expv("mispred_cnt", m);
        chk(bp.branch_cnt_o);
        chk(bp.mispred_cnt_o);
    endtask

    task automatic res_chk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic pt, input logic mp, input logic [31:0] rd);
        expv("res_pred_taken", {31'd0, pt});
        expv("res_mispredict", {31'd0, mp});
        expv("res_redirect", rd);
        res_fb(pc, tk, tgt);
        chk({31'd0, bp.pred_taken_o});
        chk({31'd0, bp.mispredict_o});
        chk(bp.redirect_pc_o);
    endtask

    initial begin
        rst_n               = 1'b0;
        bp.if_pc_i          = 32'd0;
        bp.ex_valid_i       = 1'b0;
        bp.ex_is_branch_i   = 1'b0;
        bp.ex_pc_i          = 32'd0;
        bp.ex_taken_i       = 1'b0;
        bp.ex_target_i      = 32'd0;
        bp.ex_pred_taken_i  = 1'b0;
        bp.ex_pred_target_i = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        idle_look(32'h40);
        look_chk(1'b0, 32'h44);
        mp_chk(1'b0, 32'h0);
        cnt_chk(32'd0, 32'd0);

        // Loop branch 0x40 -> 0x30: taken x3 then exit
        res_chk(32'h40, 1'b1, 32'h30, 1'b0, 1'b1, 32'h30);
        res_chk(32'h40, 1'b1, 32'h30, 1'b1, 1'b0, 32'h0);
        res_chk(32'h40, 1'b1, 32'h30, 1'b1, 1'b0, 32'h0);
        res_chk(32'h40, 1'b0, 32'h0,  1'b1, 1'b1, 32'h44);
        idle_look(32'h40);
        look_chk(1'b1, 32'h30);
        cnt_chk(32'd4, 32'd2);
        expv("ctr_idx0", 32'd2);
        chk({30'd0, dut.ctr_q[0]});

        // Not-taken miss at 0x80 must not allocate
        res_chk(32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle_look(32'h80);
        look_chk(1'b0, 32'h84);
        idle_look(32'h40);
        look_chk(1'b1, 32'h30);
        cnt_chk(32'd5, 32'd2);

        // Wrong target: stored 0x100, actual 0x200
        res_chk(32'h104, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100);
        res_chk(32'h104, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
        idle_look(32'h104);
        look_chk(1'b1, 32'h200);
        cnt_chk(32'd7, 32'd4);

        // Alias: 0x80 evicts 0x40 (same index 0)
        res_chk(32'h80, 1'b1, 32'h90, 1'b0, 1'b1, 32'h90);
        idle_look(32'h40);
        look_chk(1'b0, 32'h44);
        idle_look(32'h80);
        look_chk(1'b1, 32'h90);
        expv("ctr_alias", 32'd2);
        chk({30'd0, dut.ctr_q[0]});
        cnt_chk(32'd8, 32'd5);

        // Same-cycle lookup and allocation of 0x40: old contents, then new
        res_chk(32'h40, 1'b1, 32'h30, 1'b0, 1'b1, 32'h30);
        idle_look(32'h40);
        look_chk(1'b1, 32'h30);
        cnt_chk(32'd9, 32'd6);

        // Non-resolving cycles leave everything untouched
        drive_ex(1'b0, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
        mp_chk(1'b0, 32'h0);
        drive_ex(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h30);
        mp_chk(1'b0, 32'h0);
        idle_look(32'h40);
        look_chk(1'b1, 32'h30);
        expv("ctr_nores", 32'd2);
        chk({30'd0, dut.ctr_q[0]});
        cnt_chk(32'd9, 32'd6);

        // PC wrap-around
        idle_look(32'hFFFF_FFFC);
        look_chk(1'b0, 32'h0);
        drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
        mp_chk(1'b1, 32'h0);
        idle_look(32'h40);
        cnt_chk(32'd10, 32'd7);

        // Reset during a resolve cycle wins
        drive_ex(1'b1, 1'b1, 32'h40, 1'b1, 32'h30, 1'b0, 32'h0);
        rst_n = 1'b0;
        idle_look(32'h40);
        rst_n = 1'b1;
        #1;
        look_chk(1'b0, 32'h44);
        cnt_chk(32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor sitting between the IF stage and the EX-stage branch unit of the RV32I pipeline. IF presents each fetch PC and receives a taken/target prediction in the same cycle. EX reports each resolved branch back; the block updates its table and flags mispredictions with the corrected redirect PC. The block also keeps branch and misprediction counters that the branch bench reads.

## Interface
- ENTRIES, 16: BTB/counter entries, power of two ≥ 2, direct-mapped.
- IDX_W, $clog2(ENTRIES): index width. Index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W: tag = pc[31:IDX_W+2].

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- if_pc_i  in  32  fetch PC.
- pred_taken_o  out  1  predict taken for if_pc_i (combinational).
- pred_target_o  out  32  predicted target. Equals if_pc_i+4 when not predicted taken.
- ex_valid_i  in  1  EX holds a resolved instruction this cycle.
- ex_is_branch_i  in  1  instruction is a conditional branch (B-type).
- ex_pc_i  in  32  PC of the resolved branch.
- ex_taken_i  in  1  actual outcome, from the branch unit's branch_taken.
- ex_target_i  in  32  actual target, from the branch unit's branch_target.
- ex_pred_taken_i  in  1  prediction made at fetch, carried down the pipe.
- ex_pred_target_i  in  32  predicted target carried down the pipe.
- mispredict_o  out  1  flush and redirect this cycle (combinational).
- redirect_pc_o  out  32  correct next PC when mispredict_o=1, else 0.
- branch_cnt_o  out  32  resolved branches counted since reset.
- mispred_cnt_o  out  32  mispredictions counted since reset.

## Operation
- Per entry state: valid bit, tag[TAG_W], target[32], ctr[2] (2-bit saturating; 00 = strong not-taken … 11 = strong taken).
- Lookup: hit = valid[idx] && tag[idx]==if_pc_i tag. pred_taken_o = hit && ctr[idx][1]. pred_target_o = pred_taken_o ? target[idx] : if_pc_i+4.
- Resolve is active when ex_valid_i && ex_is_branch_i (call this "res").
- Misprediction:
  - Case 1: ex_taken_i && (!ex_pred_taken_i || ex_pred_target_i != ex_target_i). redirect_pc_o = ex_target_i.
  - Case 2: !ex_taken_i && ex_pred_taken_i. redirect_pc_o = ex_pc_i+4.
  - Otherwise mispredict_o=0.
  - mispredict_o is forced 0 when res=0.
- Table update on the res clock edge, using the index and tag of ex_pc_i:
  - Hit, taken: ctr = min(ctr+1, 3); target = ex_target_i.
  - Hit, not taken: ctr = max(ctr−1, 0).
  - Miss, taken: allocate the entry (overwriting any prior entry). valid=1, tag written, target = ex_target_i, ctr = 2'b10.
  - Miss, not taken: no change.
- Counters, on the res edge:
  - branch_cnt_o increments by 1.
  - mispred_cnt_o increments by 1 when mispredict_o=1.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- Non-branch instructions (ex_is_branch_i=0) and JAL/JALR never touch the table or the counters.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.

## Timing
- Reset (rst_n=0 at a posedge): all valid=0, all ctr=2'b01, tags and targets 0, both counters 0. Outputs after reset: pred_taken_o=0, pred_target_o=if_pc_i+4, mispredict_o=0 when res=0, redirect_pc_o=0.
- Prediction has zero-cycle latency: a combinational read of the registered table.
- An update becomes visible to lookup on the cycle after the res edge.
- Same-cycle lookup and update of the same index: lookup returns the old contents. There is no bypass.
- mispredict_o and redirect_pc_o have zero-cycle latency from the EX inputs. IF consumes them at the same edge, matching the existing taken-branch flush path.
- rst_n asserted during a res cycle: reset wins, the update is dropped, and the counters go to 0.
- Aliasing: two PCs with the same index but different tags evict each other. No error is raised.

## Test plan
- Reset, then look up if_pc_i=0x40: pred_taken_o=0, pred_target_o=0x44; both counters 0.
- Loop branch at 0x40 → 0x30, taken 3 times then not taken, with predictions fed back from the outputs:
  - Iteration 1 mispredicts (redirect 0x30).
  - Iterations 2 and 3 predict correctly.
  - The exit mispredicts (redirect 0x44).
  - Final state: branch_cnt=4, mispred_cnt=2, ctr[0x40]=11→10.
- Not-taken miss at 0x80: no allocation, mispredict_o=0; a later lookup of 0x80 returns taken=0.
- Wrong target: predicted taken to 0x100, actual taken to 0x200 → mispredict_o=1, redirect_pc_o=0x200, stored target becomes 0x200.
- Alias (ENTRIES=16): allocate 0x40, then a taken branch at 0x80 (same index). Lookup of 0x40 then misses; 0x80 hits with ctr=10.
- Simultaneous lookup and update of 0x40 on the allocation cycle: lookup returns taken=0 that cycle and taken=1 on the next cycle. ex_valid_i=0 with other inputs toggling: no state change, mispredict_o=0.
